// File: rtl/ram_string_tx.sv
// Streams a zero-terminated string (one character per 10-bit RAM word) out of RAM
// onto an 8N1 UART line, walking consecutive addresses from a given start address.
module ram_string_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] start_addr,
  output logic [9:0] mem_addr,
  input  logic [9:0] mem_rdata,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       wrap_err,
  output logic [9:0] char_count,
  output logic [2:0] fsm_state
);

  // Handshake: start is a one-cycle request that is accepted only while busy is
  // low (IDLE); a request seen while busy is high is dropped, never queued.

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    START_BIT = 3'd2,
    DATA_BITS = 3'd3,
    STOP_BIT  = 3'd4,
    DONE      = 3'd5
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state, state_n;
  logic [15:0] baud_cnt, baud_n;
  logic [2:0]  bit_idx, bit_n;
  logic [7:0]  shreg, shreg_n;
  logic [9:0]  base, base_n;
  logic [9:0]  addr_n;
  logic [9:0]  count_n;
  logic        wrap_n;
  logic        tx_n;
  logic        baud_last;
  logic [9:0]  addr_inc;
  logic        unused_hi;

  assign baud_last = (baud_cnt == BAUD_LAST);
  assign addr_inc  = mem_addr + 10'd1;
  assign unused_hi = ^mem_rdata[9:8];
  assign fsm_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      base       <= '0;
      mem_addr   <= '0;
      char_count <= '0;
      wrap_err   <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_n;
      bit_idx    <= bit_n;
      shreg      <= shreg_n;
      base       <= base_n;
      mem_addr   <= addr_n;
      char_count <= count_n;
      wrap_err   <= wrap_n;
      tx         <= tx_n;
      busy       <= (state_n != IDLE);
      done       <= (state_n == DONE);
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    shreg_n = shreg;
    base_n  = base;
    addr_n  = mem_addr;
    count_n = char_count;
    wrap_n  = wrap_err;
    unique case (state)
      IDLE: begin
        if (start) begin
          addr_n  = start_addr;
          base_n  = start_addr;
          count_n = '0;
          wrap_n  = 1'b0;
          state_n = FETCH;
        end
      end
      FETCH: begin
        baud_n = '0;
        bit_n  = '0;
        if (mem_rdata[7:0] == 8'h00) begin
          state_n = DONE;
        end else begin
          shreg_n = mem_rdata[7:0];
          state_n = START_BIT;
        end
      end
      START_BIT: begin
        if (baud_last) begin
          baud_n  = '0;
          state_n = DATA_BITS;
        end else begin
          baud_n = baud_cnt + 16'd1;
        end
      end
      DATA_BITS: begin
        if (baud_last) begin
          baud_n  = '0;
          shreg_n = {1'b0, shreg[7:1]};
          if (bit_idx == 3'd7) begin
            bit_n   = '0;
            state_n = STOP_BIT;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          baud_n = baud_cnt + 16'd1;
        end
      end
      STOP_BIT: begin
        if (baud_last) begin
          baud_n  = '0;
          count_n = (char_count == 10'd1023) ? char_count : char_count + 10'd1;
          addr_n  = addr_inc;
          // Returning to the base address means the whole RAM held no terminator.
          if (addr_inc == base) begin
            wrap_n  = 1'b1;
            state_n = DONE;
          end else begin
            state_n = FETCH;
          end
        end else begin
          baud_n = baud_cnt + 16'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // tx is registered from the next-state view so the line never glitches.
  always_comb begin
    tx_n = 1'b1;
    if (state_n == START_BIT) begin
      tx_n = 1'b0;
    end else if (state_n == DATA_BITS) begin
      tx_n = shreg_n[0];
    end
  end

endmodule

// File: tb/tb_ram_string_tx.sv
// Self-checking bench for ram_string_tx: random RAM strings compared cycle by cycle
// against a reference waveform built from the UART framing rules.
module tb_ram_string_tx;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] start_addr;
  logic [9:0] mem_addr;
  logic [9:0] mem_rdata;
  logic       tx;
  logic       busy;
  logic       done;
  logic       wrap_err;
  logic [9:0] char_count;
  logic [2:0] fsm_state;

  logic [9:0] ram [1024];

  int checks = 0;
  int errors = 0;

  logic [0:0] exp_q[$];
  int         exp_done;
  int         exp_chars;
  logic       exp_wrap;
  logic [9:0] exp_addr;

  // clock / reset
  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr];

  ram_string_tx #(.CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .tx         (tx),
    .busy       (busy),
    .done       (done),
    .wrap_err   (wrap_err),
    .char_count (char_count),
    .fsm_state  (fsm_state)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: per-cycle tx after the start edge (index 0 = first cycle).
  task automatic build_model(input logic [9:0] addr);
    logic [9:0] a;
    logic [7:0] ch;
    logic       bit_v;
    int         n;
    exp_q.delete();
    a        = addr;
    n        = 0;
    exp_wrap = 1'b0;
    forever begin
      exp_q.push_back(1'b1);
      ch = ram[a][7:0];
      if (ch == 8'h00) break;
      for (int b = 0; b < 10; b++) begin
        if (b == 0)      bit_v = 1'b0;
        else if (b == 9) bit_v = 1'b1;
        else             bit_v = ch[b-1];
        repeat (C) exp_q.push_back(bit_v);
      end
      n++;
      a = a + 10'd1;
      if (a == addr) begin
        exp_wrap = 1'b1;
        break;
      end
    end
    exp_done  = exp_q.size() + 1;
    exp_chars = (n > 1023) ? 1023 : n;
    exp_addr  = a;
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
  endtask

  // driver: one string run, optional stray start at cycle 'inject'
  task automatic run_string(input logic [9:0] addr, input int inject, input string name);
    int tx_err;
    int busy_err;
    int done_seen;
    int done_cnt;
    tx_err    = 0;
    busy_err  = 0;
    done_seen = -1;
    done_cnt  = 0;
    build_model(addr);
    @(negedge clk);
    start      = 1'b1;
    start_addr = addr;
    for (int i = 1; i <= exp_done + 1; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (tx !== exp_q[i-1][0]) begin
        if (tx_err == 0) $display("  %s first tx difference at cycle %0d", name, i);
        tx_err++;
      end
      if (busy !== (i <= exp_done)) busy_err++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_seen < 0) done_seen = i;
      end
      if (inject > 0 && i == inject) begin
        start      = 1'b1;
        start_addr = 10'($urandom);
      end
      if (inject > 0 && i == inject + 1) start = 1'b0;
    end
    check_val({name, "_tx_wave_errs"}, tx_err, 0);
    check_val({name, "_busy_wave_errs"}, busy_err, 0);
    check_val({name, "_done_cycle"}, done_seen, exp_done);
    check_val({name, "_done_pulses"}, done_cnt, 1);
    check_val({name, "_char_count"}, char_count, exp_chars);
    check_val({name, "_wrap_err"}, wrap_err, exp_wrap);
    check_val({name, "_mem_addr"}, mem_addr, exp_addr);
  endtask

  initial begin
    logic [9:0] a;
    int         len;
    int         done_cnt;
    int         tx_bad;
    int         busy_bad;

    reset      = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    for (int i = 0; i < 1024; i++) ram[i] = 10'($urandom_range(0, 1023));
    repeat (3) @(negedge clk);
    check_val("rst_tx", tx, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_wrap_err", wrap_err, 0);
    check_val("rst_char_count", char_count, 0);
    check_val("rst_mem_addr", mem_addr, 0);
    reset = 1'b0;
    @(negedge clk);

    // "Hi" string
    ram[10'h010] = 10'h048;
    ram[10'h011] = 10'h069;
    ram[10'h012] = 10'h000;
    run_string(10'h010, 0, "hi");
    check_val("hi_done_84", exp_done, 84);

    // empty string
    ram[10'h005] = 10'h000;
    run_string(10'h005, 0, "empty");

    // high bits ignored, address wraps 0x3FF -> 0x000
    ram[10'h3FF] = 10'h141;
    ram[10'h000] = 10'h000;
    run_string(10'h3FF, 0, "edge_wrap");

    // stray start during data bits
    run_string(10'h010, 2 + 2 * C, "stray_start");

    // reset in the middle of the 'H' data bits
    @(negedge clk);
    start      = 1'b1;
    start_addr = 10'h010;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_val("midrst_tx", tx, 1);
    check_val("midrst_busy", busy, 0);
    check_val("midrst_done", done, 0);
    @(negedge clk);
    reset    = 1'b0;
    done_cnt = 0;
    tx_bad   = 0;
    busy_bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (tx !== 1'b1) tx_bad++;
      if (busy !== 1'b0) busy_bad++;
    end
    check_val("midrst_no_done", done_cnt, 0);
    check_val("midrst_tx_idle", tx_bad, 0);
    check_val("midrst_busy_idle", busy_bad, 0);
    run_string(10'h010, 0, "after_rst");

    // random strings, some with stray starts
    for (int t = 0; t < 8; t++) begin
      a   = 10'($urandom);
      len = $urandom_range(0, 6);
      for (int j = 0; j < len; j++) begin
        ram[a + 10'(j)] = {2'($urandom), 8'($urandom_range(1, 255))};
      end
      ram[a + 10'(len)] = {2'($urandom), 8'h00};
      run_string(a, ($urandom_range(0, 1) == 1 && len > 0) ? $urandom_range(2, 10 * C) : 0,
                 $sformatf("rand%0d", t));
    end

    // no terminator anywhere: full walk then wrap_err
    for (int i = 0; i < 1024; i++) ram[i] = {2'($urandom), 8'($urandom_range(1, 255))};
    run_string(10'h200, 0, "full_wrap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
